// File: rtl/grabbable_object_bank.sv
// rtl/grabbable_object_bank.sv - multi-slot grabbable object drawer with double-buffered slots and 3-clock pixel pipeline
module grabbable_object_bank #(
  parameter int NUM_SLOTS = 8,
  parameter int OBJ_W = 32,
  parameter int OBJ_H = 32,
  parameter int TYPE_W = 4,
  parameter logic [7:0] TRANSPARENT = 8'hFF,
  localparam int SW = $clog2(NUM_SLOTS),
  localparam int RW = $clog2(OBJ_H),
  localparam int CW = $clog2(OBJ_W)
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic [10:0]       pixelX,
  input  logic [10:0]       pixelY,
  input  logic              startOfFrame,
  input  logic              wrEn,
  input  logic [SW-1:0]     wrSlot,
  input  logic [10:0]       wrTopLeftX,
  input  logic [10:0]       wrTopLeftY,
  input  logic [TYPE_W-1:0] wrType,
  input  logic              wrMirror,
  input  logic              clearAll,
  output logic [TYPE_W-1:0] romType,
  output logic [RW-1:0]     romRow,
  output logic [CW-1:0]     romCol,
  input  logic [7:0]        romData,
  output logic [7:0]        RGBout,
  output logic              dr,
  output logic [SW-1:0]     hitSlot
);

  logic [10:0]       sh_x [NUM_SLOTS];
  logic [10:0]       sh_y [NUM_SLOTS];
  logic [TYPE_W-1:0] sh_t [NUM_SLOTS];
  logic              sh_m [NUM_SLOTS];
  logic [10:0]       act_x [NUM_SLOTS];
  logic [10:0]       act_y [NUM_SLOTS];
  logic [TYPE_W-1:0] act_t [NUM_SLOTS];
  logic              act_m [NUM_SLOTS];

  logic [10:0]       sh_x_n [NUM_SLOTS];
  logic [10:0]       sh_y_n [NUM_SLOTS];
  logic [TYPE_W-1:0] sh_t_n [NUM_SLOTS];
  logic              sh_m_n [NUM_SLOTS];

  // Next shadow state; commit copies this so a same-cycle write is included
  always_comb begin
    for (int i = 0; i < NUM_SLOTS; i++) begin
      sh_x_n[i] = sh_x[i];
      sh_y_n[i] = sh_y[i];
      sh_t_n[i] = clearAll ? '0 : sh_t[i];
      sh_m_n[i] = sh_m[i];
    end
    if (wrEn && (int'(wrSlot) < NUM_SLOTS)) begin
      sh_x_n[wrSlot] = wrTopLeftX;
      sh_y_n[wrSlot] = wrTopLeftY;
      sh_t_n[wrSlot] = wrType;
      sh_m_n[wrSlot] = wrMirror;
    end
  end

  logic [NUM_SLOTS-1:0] hit_vec;
  logic                 any_hit;
  logic [SW-1:0]        win;

  // 12-bit bounds so boxes near the right/bottom edge clip instead of wrapping
  always_comb begin
    for (int i = 0; i < NUM_SLOTS; i++) begin
      hit_vec[i] = (act_t[i] != '0)
                && ({1'b0, pixelX} >= {1'b0, act_x[i]})
                && ({1'b0, pixelX} <  ({1'b0, act_x[i]} + 12'(OBJ_W)))
                && ({1'b0, pixelY} >= {1'b0, act_y[i]})
                && ({1'b0, pixelY} <  ({1'b0, act_y[i]} + 12'(OBJ_H)));
    end
    any_hit = |hit_vec;
    win = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (hit_vec[i]) win = SW'(i);
    end
  end

  logic [CW-1:0] off_x;
  logic [RW-1:0] off_y;
  logic [RW-1:0] row_c;
  logic [CW-1:0] col_c;

  assign off_x = pixelX[CW-1:0] - act_x[win][CW-1:0];
  assign off_y = pixelY[RW-1:0] - act_y[win][RW-1:0];
  assign row_c = RW'(OBJ_H - 1) - off_y;
  assign col_c = act_m[win] ? off_x : (CW'(OBJ_W - 1) - off_x);

  logic          s1_hit, s2_hit;
  logic [SW-1:0] s1_win, s2_win;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        sh_x[i]  <= '0;
        sh_y[i]  <= '0;
        sh_t[i]  <= '0;
        sh_m[i]  <= 1'b0;
        act_x[i] <= '0;
        act_y[i] <= '0;
        act_t[i] <= '0;
        act_m[i] <= 1'b0;
      end
      s1_hit  <= 1'b0;
      s1_win  <= '0;
      romType <= '0;
      romRow  <= '0;
      romCol  <= '0;
      s2_hit  <= 1'b0;
      s2_win  <= '0;
      RGBout  <= TRANSPARENT;
      dr      <= 1'b0;
      hitSlot <= '0;
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        sh_x[i] <= sh_x_n[i];
        sh_y[i] <= sh_y_n[i];
        sh_t[i] <= sh_t_n[i];
        sh_m[i] <= sh_m_n[i];
      end
      if (startOfFrame) begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
          act_x[i] <= sh_x_n[i];
          act_y[i] <= sh_y_n[i];
          act_t[i] <= sh_t_n[i];
          act_m[i] <= sh_m_n[i];
        end
      end
      s1_hit  <= any_hit;
      s1_win  <= win;
      romType <= any_hit ? act_t[win] : '0;
      romRow  <= any_hit ? row_c : '0;
      romCol  <= any_hit ? col_c : '0;
      // Hit/winner travel alongside the one-clock ROM read
      s2_hit  <= s1_hit;
      s2_win  <= s1_win;
      if (s2_hit && (romData != TRANSPARENT)) begin
        RGBout  <= romData;
        dr      <= 1'b1;
        hitSlot <= s2_win;
      end else begin
        RGBout  <= TRANSPARENT;
        dr      <= 1'b0;
        hitSlot <= '0;
      end
    end
  end

endmodule
